// File: rtl/store_buffer_ctrl.sv
// Store-side dmem controller: aligns SB/SH/SW stores into a small FIFO and
// arbitrates the single dmem port between loads and buffered stores.
module store_buffer_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [2:0]    st_funct3,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_grant,
  output logic          ld_stall,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;

  logic [AW-1:0] r_waddr [DEPTH];
  logic [31:0]   r_data  [DEPTH];
  logic [3:0]    r_mask  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_empty;

  logic [31:0]   w_enq_data;
  logic [3:0]    w_enq_mask;
  logic          w_fnc_ok;
  logic          w_enq;
  logic          w_deq;
  logic          w_full;
  logic          w_hit;
  logic          w_hazard;
  logic [AW-1:0] w_ld_waddr;
  logic [AW-1:0] w_st_waddr;
  logic [CW-1:0] w_count_nxt;
  logic          w_unused;

  assign w_unused   = ^{ld_addr[31:AW+2], ld_addr[1:0], st_addr[31:AW+2]};
  assign w_ld_waddr = ld_addr[AW+1:2];
  assign w_st_waddr = st_addr[AW+1:2];
  assign w_full     = (r_count == CW'(DEPTH));
  assign st_ready   = ~rst & ~w_full;
  assign empty      = r_empty;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_enq_data = '0;
    w_enq_mask = '0;
    w_fnc_ok   = 1'b0;
    case (st_funct3)
      FNC_SB: begin
        w_enq_data = {24'b0, st_data[7:0]} << {st_addr[1:0], 3'b000};
        w_enq_mask = 4'b0001 << st_addr[1:0];
        w_fnc_ok   = 1'b1;
      end
      FNC_SH: begin
        w_enq_data = st_addr[1] ? {st_data[15:0], 16'b0} : {16'b0, st_data[15:0]};
        w_enq_mask = st_addr[1] ? 4'b1100 : 4'b0011;
        w_fnc_ok   = 1'b1;
      end
      FNC_SW: begin
        w_enq_data = st_data;
        w_enq_mask = 4'b1111;
        w_fnc_ok   = 1'b1;
      end
      default: ;
    endcase
  end

  // Unknown funct3 still handshakes but never occupies a slot.
  assign w_enq = st_valid & st_ready & w_fnc_ok;

  // Only already-buffered entries count; a same-cycle store is younger than the load.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_waddr[i] == w_ld_waddr)) w_hit = 1'b1;
    end
  end
  assign w_hazard = ld_valid & w_hit;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'b0000;
    mem_addr = '0;
    mem_din  = '0;
    ld_grant = 1'b0;
    w_deq    = 1'b0;
    if (!rst) begin
      if (w_full || !(ld_valid && !w_hazard)) begin
        if (r_count != '0) begin
          mem_en   = 1'b1;
          mem_we   = r_mask[r_head];
          mem_addr = r_waddr[r_head];
          mem_din  = r_data[r_head];
          w_deq    = 1'b1;
        end
      end else begin
        mem_en   = 1'b1;
        mem_addr = w_ld_waddr;
        ld_grant = 1'b1;
      end
    end
  end

  assign ld_stall    = ld_valid & ~ld_grant & ~rst;
  assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_deq);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_empty <= 1'b1;
    end else begin
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

  // NOTE: entry payload is deliberately not reset; the valid bits and count
  // gate every use, so clearing the storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_waddr[r_tail] <= w_st_waddr;
      r_data[r_tail]  <= w_enq_data;
      r_mask[r_tail]  <= w_enq_mask;
    end
  end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
Store-side memory controller for the RISC-V core's single-port data memory. Accepts stores from the MEM stage and converts raw rs2 data into aligned write data plus a 4-bit byte-write mask (SB/SH/SW). Holds stores in a small FIFO and arbitrates the dmem port between loads and buffered stores. Stalls a load that hits a pending store word until that store has drained.

Parameters:
DEPTH, 4, store FIFO entries; power of 2, at least 2
AW, 14, dmem word-address width; mem_addr = byte address bits [AW+1:2]

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
st_valid  input  1  store request from MEM stage
st_ready  output  1  store accepted at this edge when st_valid is also high
st_addr  input  32  store byte address
st_data  input  32  raw rs2 value, unaligned
st_funct3  input  3  FNC_SB / FNC_SH / FNC_SW
ld_valid  input  1  load request
ld_addr  input  32  load byte address
ld_grant  output  1  load owns dmem port this cycle
ld_stall  output  1  load present but not granted; core must hold it
mem_en  output  1  dmem enable
mem_we  output  4  dmem byte write enables; 0000 for a read
mem_addr  output  AW  dmem word address
mem_din  output  32  dmem write data
empty  output  1  no buffered stores

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes on the rising edge of clk.
- While rst is high, force combinationally: mem_en=0, mem_we=0, ld_grant=0, ld_stall=0, st_ready=0.
- At reset: head=0, tail=0, count=0, all entry valid bits cleared, empty=1. Reset mid-operation discards pending stores; none is written.
- Alignment is done at enqueue. Each entry holds word address, data and mask.
  - SB: data = st_data[7:0] << (8*addr[1:0]); mask = 0001 << addr[1:0].
  - SH: addr[0] is ignored. If addr[1]=0: data = st_data[15:0], mask = 0011. If addr[1]=1: data = st_data[15:0] << 16, mask = 1100.
  - SW: addr[1:0] is ignored; data = st_data; mask = 1111.
  - Any other funct3: the store is accepted (handshake completes), nothing is enqueued, count is unchanged.
- st_ready = (count != DEPTH). It is registered-state only; there is no same-cycle pass-through when a dequeue frees a slot.
- Hazard = ld_valid AND any valid entry's word address equals ld_addr[AW+1:2]. A store being enqueued in the same cycle is younger than the load and is excluded from the check.
- Port arbitration, evaluated per cycle in priority order:
  1. count == DEPTH: issue head store. If ld_valid, ld_stall=1. This guarantees forward progress.
  2. ld_valid and no hazard: mem_en=1, mem_we=0000, mem_addr=load word address, ld_grant=1.
  3. count != 0: issue head store. mem_en=1, mem_we=head mask, mem_addr=head word address, mem_din=head data. ld_stall = ld_valid. Dequeue at this edge.
  4. Otherwise mem_en=0, mem_we=0000, ld_grant=0, ld_stall=0.
- ld_stall = ld_valid AND NOT ld_grant.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged.
- Pointers wrap modulo DEPTH.
- Latency: a store enqueued at edge N is issued earliest in cycle N+1, when the port is free.
- empty = (count == 0), registered.
- mem_din is don't-care when mem_we == 0000. The bench checks it only on writes.

Test Plan:
1. SB to 0x00001003, st_data=0x000000AB, idle port -> next cycle mem_we=1000, mem_addr=0x400, mem_din=0xAB000000; empty=1 the cycle after.
2. SH to 0x00002002, data 0x00001234 -> mem_we=1100, mem_din=0x12340000. SH to 0x00002001 -> mem_we=0011, mem_din=0x00001234.
3. Hold ld_valid=1 at 0x8000 (no hazard) and send 4 back-to-back SWs.
   - Loads win until count=4, then st_ready=0.
   - The next cycle drains the head with ld_stall=1.
   - st_ready returns to 1 the following cycle.
4. Enqueue SW 0x00000100 data 0xDEADBEEF while the port is busy with loads, then LW 0x00000100.
   - ld_stall=1 and the buffered entry is written: mem_we=1111, mem_din=0xDEADBEEF.
   - ld_grant=1 the next cycle.
5. With 3 entries pending, assert rst for one cycle -> empty=1 and st_ready=1 after reset; no mem_we ever asserted for the discarded entries.
6. st_funct3=3'b011 with st_valid=1 -> handshake completes, count unchanged, no dmem write.
